piece_queue: RTL
================

Name: piece_queue

Overview:
- Consumes the free-running 3-bit piece code (1..7) from the random number generator and holds a FIFO of upcoming Tetris pieces.
- Hands the head piece to the game FSM on request and exposes the remaining entries as a "next piece" preview for the display logic.
- Screens out invalid codes and optionally blocks immediate repeats of the same piece.

Parameters:
DEPTH, 3, number of queued entries (1 head + DEPTH-1 preview), 2..7
NO_REPEAT, 1, when 1 reject a sampled code equal to the last enqueued code (once per slot)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
random_in  input  3  piece code from generator; valid codes 1..7, 0 invalid
piece_req  input  1  game FSM requests next piece (level, sampled each cycle)
flush  input  1  synchronous clear of queue (new game)
piece_out  output  3  last dispensed piece code
piece_valid  output  1  one-cycle pulse: piece_out updated this cycle
preview  output  3*DEPTH  entry i at bits [3i+2:3i], entry 0 = head; empty entries read 0
count  output  3  number of valid entries, 0..DEPTH
ready  output  1  count == DEPTH

Behaviour:
- Reset (rst_n low, async): all entries = 0, count = 0, piece_out = 0, piece_valid = 0, last_enq = 0, rej = 0, state = FILL.
- States: FILL (count < DEPTH) and READY (count == DEPTH). Both states derive from count and are also visible as the ready output. No separate transitions beyond count changes and flush.
- pop = piece_req && count != 0.
  - On pop: piece_out <= entry0, piece_valid <= 1 next cycle, entries shift down one (entry i <= entry i+1), top vacated entry <= 0.
  - piece_req with count == 0: ignored; no pulse; piece_out holds its value.
- Accept rule, evaluated per cycle:
  - Let cnt_p = count - pop.
  - push = (cnt_p < DEPTH) && random_in != 0 && !(NO_REPEAT && random_in == last_enq && !rej).
  - On push, random_in is written to entry[cnt_p] after any shift, and last_enq <= random_in.
- Repeat screening:
  - When a code is rejected only because of a repeat, rej <= 1.
  - The next valid code is then accepted even if it equals last_enq; rej clears on any push.
  - A code of 0 neither sets nor clears rej.
- Simultaneous pop and push in one cycle: count is unchanged. The pushed code lands at entry[count-1].
- Latency:
  - Sample to visible in preview: 1 cycle.
  - Request to piece_out/piece_valid: 1 cycle.
  - Back-to-back requests dispense one piece per cycle while count > 0.
- count never exceeds DEPTH and never underflows. Pushes while full (no pop) are dropped; last_enq and rej are unchanged.
- flush (synchronous, highest priority over pop/push):
  - Entries = 0, count = 0, last_enq = 0, rej = 0, piece_valid = 0.
  - piece_out holds.
  - random_in is not sampled that cycle.
- rst_n asserted mid-operation: immediate return to the reset values, including clearing a pending piece_valid.

Test Plan:
- Reset release, generator stepping 1,2,3,4...: count 1,2,3 over 3 cycles; preview = {3,2,1} (entry0 = 1); ready = 1 on the cycle count reaches 3.
- Full queue {1,2,3}, single piece_req while random_in = 5: next cycle piece_out = 1 with piece_valid pulse; preview = {5,3,2}; count stays 3.
- Empty queue, random_in = 0, piece_req held high: no piece_valid; count stays 0; piece_out stays 0.
- NO_REPEAT = 1, random_in held at 4 from reset: cycle 1 accepts 4; cycle 2 rejected (rej = 1); cycle 3 accepts 4. Result: count = 2, entries {4,4}.
- Full queue, piece_req held 4 cycles with generator running: four consecutive piece_valid pulses. piece_out sequence = original head, then the following entries in order, then newly sampled codes. count remains 3 throughout.
- flush asserted together with piece_req on a full queue: no piece_valid; count = 0 next cycle; refill restarts from the next random_in.
- rst_n pulsed low mid-stream: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/piece_queue.sv
// piece_queue: FIFO of upcoming Tetris pieces fed by a free-running 3-bit
// generator. The head is dispensed on request, the remaining entries form
// the "next piece" preview. Invalid codes (0) are skipped and, optionally,
// an immediate repeat of the last enqueued code is rejected once per slot.
//
// Handshake: piece_req is a level request sampled every cycle; a request is
// honoured only when count != 0, and the dispensed code appears on
// piece_out together with a single-cycle piece_valid pulse one cycle later.
// Requests against an empty queue are silently ignored (no pulse).
//
// Controller state (FILL / READY) tracks whether the queue is full and is
// exposed directly on the ready output.
module piece_queue #(
    parameter int DEPTH     = 3,    // entries: 1 head + DEPTH-1 preview, 2..7
    parameter bit NO_REPEAT = 1'b1  // reject a code equal to the last enqueued
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           random_in,
    input  logic                 piece_req,
    input  logic                 flush,
    output logic [2:0]           piece_out,
    output logic                 piece_valid,
    output logic [3*DEPTH-1:0]   preview,
    output logic [2:0]           count,
    output logic                 ready
);

    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Registered state
    state_t     r_state;
    logic [2:0] r_entry [DEPTH];
    logic [2:0] r_count;
    logic [2:0] r_piece_out;
    logic       r_piece_valid;
    logic [2:0] r_last_enq;
    logic       r_rej;

    // Next-state values
    logic       w_pop;
    logic [2:0] w_cnt_p;
    logic       w_room;
    logic       w_code_ok;
    logic       w_repeat;
    logic       w_push;
    logic       w_rej_set;
    logic [2:0] w_entry_n [DEPTH];
    logic [2:0] w_count_n;
    logic [2:0] w_last_enq_n;
    logic       w_rej_n;
    state_t     w_state_n;

    // Pop/push decision for this cycle; push sees the count after any pop
    always_comb begin
        w_pop     = piece_req && (r_count != 3'd0);
        w_cnt_p   = r_count - {2'b00, w_pop};
        w_room    = (w_cnt_p < DEPTH_C);
        w_code_ok = (random_in != 3'd0);
        w_repeat  = NO_REPEAT && (random_in == r_last_enq) && !r_rej;
        w_push    = w_room && w_code_ok && !w_repeat;
        // Only a repeat that would otherwise have been accepted arms the bypass
        w_rej_set = w_room && w_code_ok && w_repeat;
    end

    // Next entries/count/screening state; flush overrides everything
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_entry_n[i] = r_entry[i];
        end
        w_count_n    = r_count;
        w_last_enq_n = r_last_enq;
        w_rej_n      = r_rej;

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                w_entry_n[i] = 3'd0;
            end
            w_count_n    = 3'd0;
            w_last_enq_n = 3'd0;
            w_rej_n      = 1'b0;
        end else begin
            if (w_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    w_entry_n[i] = r_entry[i+1];
                end
                w_entry_n[DEPTH-1] = 3'd0;
            end
            if (w_push) begin
                // Written after the shift so simultaneous pop+push lands at count-1
                for (int i = 0; i < DEPTH; i++) begin
                    if (i == int'(w_cnt_p)) begin
                        w_entry_n[i] = random_in;
                    end
                end
                w_last_enq_n = random_in;
                w_rej_n      = 1'b0;
            end else if (w_rej_set) begin
                w_rej_n = 1'b1;
            end
            w_count_n = w_cnt_p + {2'b00, w_push};
        end

        w_state_n = (w_count_n == DEPTH_C) ? ST_READY : ST_FILL;
    end

    // Controller FSM and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= 3'd0;
            end
            r_count       <= 3'd0;
            r_piece_out   <= 3'd0;
            r_piece_valid <= 1'b0;
            r_last_enq    <= 3'd0;
            r_rej         <= 1'b0;
        end else begin
            r_state <= w_state_n;
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= w_entry_n[i];
            end
            r_count    <= w_count_n;
            r_last_enq <= w_last_enq_n;
            r_rej      <= w_rej_n;
            if (flush) begin
                r_piece_valid <= 1'b0;
            end else begin
                r_piece_valid <= w_pop;
                if (w_pop) begin
                    r_piece_out <= r_entry[0];
                end
            end
        end
    end

    // Flatten the entries into the preview bus, entry 0 in the low bits
    always_comb begin
        preview = '0;
        for (int i = 0; i < DEPTH; i++) begin
            preview[3*i +: 3] = r_entry[i];
        end
    end

    assign piece_out   = r_piece_out;
    assign piece_valid = r_piece_valid;
    assign count       = r_count;
    assign ready       = (r_state == ST_READY);

endmodule
